// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, opcodes,
// ALUOp codes (also consumed by alu_control) and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StTrap     = 4'd11
  } state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Unified instruction/data memory port: req/ready handshake plus address select.
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the cycle on which the
// limit is reached without mem_ready. MEM_WAIT_MAX = 0 disables the timeout.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 0,
  parameter int unsigned WAIT_CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic timeout
);

  // Limit wraps to all-ones when disabled; the enable term masks it.
  localparam logic [WAIT_CNT_W-1:0] Limit = WAIT_CNT_W'(MEM_WAIT_MAX - 32'd1);
  localparam bit Enabled = (MEM_WAIT_MAX != 0);

  logic [WAIT_CNT_W-1:0] cnt_q;

  assign timeout = Enabled && waiting && (cnt_q == Limit);

  // Any non-waiting cycle covers both "ready seen" and "state left".
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (waiting && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM. Define ILLEGAL_TRAP_EN to trap on unknown
// opcodes; otherwise they retire as NOPs from DECODE.
module mc_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0,
  parameter int unsigned WAIT_CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              opcode,
  input  logic                    zero,
  mc_control_fsm_if.master        bus,
  output logic                    ir_write,
  output logic                    pc_en,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              ALUOp,
  output logic [1:0]              result_src,
  output logic                    reg_write,
  output logic                    instr_done,
  output logic                    trap,
  output logic [3:0]              state_o
);

  state_t state_q, state_d;
  logic   trap_q;
  logic   waiting, timeout;

  assign waiting = (state_q inside {StFetch, StMemRead, StMemWrite}) && !bus.mem_ready;

  mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .WAIT_CNT_W   (WAIT_CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (timeout) state_d = StTrap; else if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = StMemAdr;
          OPC_RTYPE:           state_d = StExecR;
          OPC_ITYPE:           state_d = StExecI;
          OPC_JAL:             state_d = StJal;
          OPC_BEQ:             state_d = StBeq;
`ifdef ILLEGAL_TRAP_EN
          default:             state_d = StTrap;
`else
          default:             state_d = StFetch;
`endif
        endcase
      end
      StMemAdr:   state_d = (opcode == OPC_LOAD) ? StMemRead : StMemWrite;
      StMemRead:  if (timeout) state_d = StTrap; else if (bus.mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (timeout) state_d = StTrap; else if (bus.mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StBeq:      state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) trap_q <= 1'b1;
    end
  end

  // Moore decode; only handshake-completion terms look at mem_ready.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.adr_src = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    result_src  = RES_ALUOUT;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          bus.mem_req = 1'b1;
          alu_src_b   = SRCB_FOUR;
          result_src  = RES_ALU;
          ir_write    = bus.mem_ready;
          pc_en       = bus.mem_ready;
        end
        StDecode: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
`ifndef ILLEGAL_TRAP_EN
          instr_done = (state_d == StFetch);
`endif
        end
        StMemAdr: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        StMemRead: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        StMemWb: begin
          result_src = RES_MEM;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        StMemWrite: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.adr_src = 1'b1;
          instr_done  = bus.mem_ready;
        end
        StExecR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          ALUOp     = ALUOP_FUNCT;
        end
        StExecI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          ALUOp     = ALUOP_FUNCT;
        end
        StAluWb: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        StJal: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_en     = 1'b1;
        end
        StBeq: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          ALUOp      = ALUOP_SUB;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap    = trap_q && !reset;
  assign state_o = reset ? StFetch : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected control-word sequences
// are planned into a queue, then replayed cycle by cycle against the DUT.
module tb_mc_control_fsm;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       ir_write, pc_en, reg_write, instr_done, trap;
  logic [1:0] alu_src_a, alu_src_b, ALUOp, result_src;
  logic [3:0] state_o;

  mc_control_fsm_if bus ();

  mc_control_fsm #(
    .MEM_WAIT_MAX (4),
    .WAIT_CNT_W   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .bus        (bus),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ALUOp      (ALUOp),
    .result_src (result_src),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .trap       (trap),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, adr, irw, pce;
    logic [1:0] a, b, op, res;
    logic       rw, done, trp;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    logic [6:0] opc;
    logic       z;
    logic       rdy;
    ctl_t       c;
    string      tag;
  } step_t;

  step_t q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  ctl_t  obs;

  always_comb obs = {bus.mem_req, bus.mem_we, bus.adr_src, ir_write, pc_en, alu_src_a,
                     alu_src_b, ALUOp, result_src, reg_write, instr_done, trap, state_o};

  function automatic ctl_t mk(state_t st, logic req, logic we, logic adr, logic irw, logic pce,
                              logic [1:0] a, logic [1:0] b, logic [1:0] op, logic [1:0] res,
                              logic rw, logic done, logic trp);
    mk = {req, we, adr, irw, pce, a, b, op, res, rw, done, trp, 4'(st)};
  endfunction

  function automatic logic rbit();
    rbit = 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(logic [6:0] opc, logic z, logic rdy, ctl_t c, string tag);
    q.push_back('{opc: opc, z: z, rdy: rdy, c: c, tag: tag});
  endfunction

  task automatic check(string tag, ctl_t exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // fs = fetch stall cycles, ms = memory stall cycles; ms >= 4 plans a timeout.
  task automatic plan_instr(logic [6:0] opc, logic z, int fs, int ms);
    ctl_t trap_w, wb_w, mem_w;
    logic legal, nop_done;
    trap_w = mk(StTrap, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    wb_w   = mk(StAluWb, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, RES_ALUOUT, 1, 1, 0);
    legal  = opc inside {OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_ITYPE, OPC_JAL, OPC_BEQ};
`ifdef ILLEGAL_TRAP_EN
    nop_done = 1'b0;
`else
    nop_done = !legal;
`endif
    for (int k = 0; k < fs; k++)
      push(opc, z, 0, mk(StFetch, 1, 0, 0, 0, 0, SRCA_PC, SRCB_FOUR, ALUOP_ADD, RES_ALU, 0, 0, 0),
           "fetch_wait");
    push(opc, z, 1, mk(StFetch, 1, 0, 0, 1, 1, SRCA_PC, SRCB_FOUR, ALUOP_ADD, RES_ALU, 0, 0, 0),
         "fetch");
    push(opc, z, rbit(), mk(StDecode, 0, 0, 0, 0, 0, SRCA_OLDPC, SRCB_IMM, ALUOP_ADD, RES_ALUOUT,
                            0, nop_done, 0), "decode");
    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
      for (int k = 0; k < 20; k++) push(opc, z, rbit(), trap_w, "illegal_trap");
`endif
    end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
      push(opc, z, rbit(), mk(StMemAdr, 0, 0, 0, 0, 0, SRCA_RS1, SRCB_IMM, ALUOP_ADD, RES_ALUOUT,
                              0, 0, 0), "memadr");
      mem_w = (opc == OPC_LOAD) ? mk(StMemRead, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)
                                : mk(StMemWrite, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < ms && k < 4; k++) push(opc, z, 0, mem_w, "mem_wait");
      if (ms >= 4) begin
        for (int k = 0; k < 5; k++) push(opc, z, rbit(), trap_w, "timeout_trap");
      end else if (opc == OPC_LOAD) begin
        push(opc, z, 1, mem_w, "memread_done");
        push(opc, z, rbit(), mk(StMemWb, 0, 0, 0, 0, 0, 0, 0, 0, RES_MEM, 1, 1, 0), "memwb");
      end else begin
        mem_w.done = 1'b1;
        push(opc, z, 1, mem_w, "memwrite_done");
      end
    end else if (opc == OPC_RTYPE) begin
      push(opc, z, rbit(), mk(StExecR, 0, 0, 0, 0, 0, SRCA_RS1, SRCB_RS2, ALUOP_FUNCT, RES_ALUOUT,
                              0, 0, 0), "exec_r");
      push(opc, z, rbit(), wb_w, "aluwb");
    end else if (opc == OPC_ITYPE) begin
      push(opc, z, rbit(), mk(StExecI, 0, 0, 0, 0, 0, SRCA_RS1, SRCB_IMM, ALUOP_FUNCT, RES_ALUOUT,
                              0, 0, 0), "exec_i");
      push(opc, z, rbit(), wb_w, "aluwb");
    end else if (opc == OPC_JAL) begin
      push(opc, z, rbit(), mk(StJal, 0, 0, 0, 0, 1, SRCA_OLDPC, SRCB_FOUR, ALUOP_ADD, RES_ALUOUT,
                              0, 0, 0), "jal");
      push(opc, z, rbit(), wb_w, "aluwb");
    end else begin
      push(opc, z, rbit(), mk(StBeq, 0, 0, 0, 0, z, SRCA_RS1, SRCB_RS2, ALUOP_SUB, RES_ALUOUT,
                              0, 1, 0), "beq");
    end
  endtask

  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset         = 1'b0;
      opcode        = s.opc;
      zero          = s.z;
      bus.mem_ready = s.rdy;
      cyc++;
      #1;
      check(s.tag, s.c);
    end
  endtask

  task automatic do_reset(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset         = 1'b1;
      opcode        = 7'($urandom);
      bus.mem_ready = rbit();
      cyc++;
      #1;
      check("reset", '0);
    end
  endtask

  initial begin
    logic [6:0] opc;
    bus.mem_ready = 1'b0;
    do_reset(2);

    plan_instr(OPC_RTYPE, 0, 0, 0); run_q();
    plan_instr(OPC_LOAD, 0, 0, 3);  run_q();
    plan_instr(OPC_BEQ, 1, 0, 0);   run_q();
    plan_instr(OPC_BEQ, 0, 0, 0);   run_q();
    plan_instr(OPC_JAL, 0, 1, 0);   run_q();
    plan_instr(OPC_ITYPE, 0, 2, 0); run_q();

    plan_instr(7'b1111111, 0, 0, 0); run_q();
`ifdef ILLEGAL_TRAP_EN
    do_reset(2);
`endif
    plan_instr(OPC_RTYPE, 0, 0, 0); run_q();

    // store timeout, then store completing on the limit cycle
    plan_instr(OPC_STORE, 0, 0, 4); run_q();
    do_reset(2);
    plan_instr(OPC_STORE, 0, 0, 3); run_q();
    plan_instr(OPC_RTYPE, 0, 0, 0); run_q();

    // reset in the middle of a store wait
    plan_instr(OPC_STORE, 0, 0, 3);
    void'(q.pop_back());
    void'(q.pop_back());
    run_q();
    do_reset(1);
    plan_instr(OPC_RTYPE, 0, 0, 0); run_q();
    plan_instr(OPC_STORE, 0, 0, 0); run_q();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0: opc = OPC_LOAD;
        1: opc = OPC_STORE;
        2: opc = OPC_RTYPE;
        3: opc = OPC_ITYPE;
        4: opc = OPC_JAL;
        5: opc = OPC_BEQ;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          opc = OPC_ITYPE;
`else
          do opc = 7'($urandom);
          while (opc inside {OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_ITYPE, OPC_JAL, OPC_BEQ});
`endif
        end
      endcase
      plan_instr(opc, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
      run_q();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle main control FSM for the RISC-V core. It sequences the shared ALU, register file, IR and the unified instruction/data memory port over several cycles per instruction. Each cycle it drives the 2-bit ALUOp consumed by alu_control, plus all mux selects and write enables. Memory accesses use a req/ready handshake with an optional wait timeout.

Parameters:
MEM_WAIT_MAX, 0, max consecutive cycles waiting on mem_ready before bus error; 0 = unlimited (no timeout)
WAIT_CNT_W, 8, width of the wait counter; MEM_WAIT_MAX must be < 2**WAIT_CNT_W

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from IR; stable after ir_write
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write access (valid with mem_req)
adr_src  out  1  0 = PC, 1 = ALUOut
ir_write  out  1  load IR and oldPC
pc_en  out  1  PC load enable
alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse on last cycle of each instruction
trap  out  1  sticky; set on entering TRAP, cleared only by reset
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset: state <= FETCH, wait counter <= 0, trap <= 0. While reset is high, all outputs are forced to 0. Reset mid-access drops mem_req the same cycle with no writes.
- Outputs are Moore per state, default 0. Exception: ir_write, pc_en and the exit transition in memory states are gated by mem_ready.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, ALUOp=00, result_src=10. On mem_ready: ir_write=1, pc_en=1, go to DECODE. Otherwise hold.
- DECODE: a=01, b=01, ALUOp=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - other -> illegal handling (see Optional Feature)
- MEMADR: a=10, b=01, ALUOp=00. Go to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: instr_done=1, go to FETCH.
- EXEC_R: a=10, b=00, ALUOp=10, go to ALUWB.
- EXEC_I: a=10, b=01, ALUOp=10, go to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, go to FETCH.
- JAL: a=01, b=10, ALUOp=00, result_src=00, pc_en=1, go to ALUWB (writes oldPC+4).
- BEQ: a=10, b=00, ALUOp=01, result_src=00, pc_en=zero, instr_done=1, go to FETCH.
- TRAP: all outputs 0 except trap=1. Absorbing until reset.
- Wait counter (MEM_WAIT_MAX>0):
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on any state change.
  - When the count reaches MEM_WAIT_MAX and mem_ready=0, go to TRAP next cycle.
  - mem_ready on the same cycle the limit is reached wins: normal completion.
- Latencies with mem_ready always 1: R/I = 4 cycles, lw = 5, sw = 4, beq = 3, jal = 4.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: unknown opcode in DECODE goes to TRAP (trap=1, sticky).
- Undefined: unknown opcode executes as NOP: DECODE asserts instr_done=1 and goes to FETCH. No reg/mem writes, PC already advanced. trap asserts only on memory timeout.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state_t enum (4-bit) for the 12 states
  - opcode constants: OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_ITYPE, OPC_JAL, OPC_BEQ
  - ALUOp constants: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10, shared with alu_control
  - SRCA_*, SRCB_*, RES_* select constants
- One sub-module: mem_wait_timer (counter, clear, limit compare, timeout flag), parameterised by MEM_WAIT_MAX and WAIT_CNT_W.

Test Plan:
- reset 2 cycles, then opcode=0110011, mem_ready=1 -> states FETCH,DECODE,EXEC_R,ALUWB. ALUOp=10 in EXEC_R; reg_write and instr_done in cycle 4; back in FETCH cycle 5.
- opcode=0000011, mem_ready low 3 cycles in MEMREAD -> mem_req=1, adr_src=1 held 4 cycles. MEMWB has result_src=01, reg_write=1. Total 8 cycles.
- opcode=1100011 with zero=1 -> BEQ asserts ALUOp=01, pc_en=1. Repeat with zero=0 -> pc_en=0. Both give instr_done and FETCH next.
- opcode=1111111 -> with ILLEGAL_TRAP_EN: TRAP, trap=1 stays 1 for 20 cycles until reset. Without: instr_done in DECODE, next FETCH, trap=0.
- MEM_WAIT_MAX=4, opcode=0100011, mem_ready=0 -> 4 wait cycles in MEMWRITE, then TRAP, trap=1, mem_req=0. Rerun with mem_ready=1 on the 4th wait cycle -> normal completion, no trap.
- reset asserted during MEMWRITE wait -> next cycle state_o=FETCH encoding, outputs 0 while reset high, no mem_we pulse after reset deasserts until a new store.
